uart_tx_ser: RTL
================

Name: uart_tx_ser

Overview:
- UART transmit serializer: pops bytes from the TX FIFO and drives the `o_tx` line as LSB-first async frames.
- Frame format: start bit, DATA_WIDTH data bits, optional parity bit, 1 or 2 stop bits.
- Bit period is chosen at run time by `set_bps`/`set_clk_freq`, the same encoding used on the receive side.
- Sits between the TX FIFO read port and the `o_tx` pad inside `uart_top`.

Parameters:
- DATA_WIDTH, 8: frame data bits; equals FIFO width.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.

Ports:
- i_sys_clk  in  1  system clock
- i_sys_rst_n  in  1  reset; synchronous, active-low
- i_tx_en  in  1  permit new frames; a frame in progress always completes
- set_bps  in  3  baud select: 0=2400 1=4800 2=9600 3=19200 4=38400 5=57600 6=115200 7=230400
- set_clk_freq  in  1  clock select: 1=50 MHz, 0=25 MHz
- i_fifo_empty  in  1  TX FIFO empty
- i_fifo_rdata  in  DATA_WIDTH  FIFO read data; valid the cycle after `o_fifo_rden`
- o_fifo_rden  out  1  one-cycle FIFO pop
- o_tx  out  1  serial line, idle high
- o_busy  out  1  frame in progress
- o_byte_done  out  1  one-cycle pulse per completed frame
- o_finsh_flag  out  1  one-cycle pulse when a frame completes and the FIFO is empty

Behaviour:
- Reset values: `o_tx`=1; `o_fifo_rden`, `o_busy`, `o_byte_done`, `o_finsh_flag`=0; state IDLE; counters 0. All outputs are registered.
- Divisor DIV = round(fclk/baud); 15-bit counter.
  - 50 MHz: 20833, 10417, 5208, 2604, 1302, 868, 434, 217.
  - 25 MHz: 10417, 5208, 2604, 1302, 651, 434, 217, 109.
- State machine:
  - IDLE: `i_tx_en`=1 and `i_fifo_empty`=0 sampled → RD.
  - RD: `o_fifo_rden`=1 for exactly this cycle; `o_busy`=1 → LOAD.
  - LOAD: capture `i_fifo_rdata` into the shift register; latch DIV from `set_bps`/`set_clk_freq`; compute parity → START.
  - START: `o_tx`=0 for DIV cycles → DATA.
  - DATA: bit index 0..DATA_WIDTH-1, LSB first, DIV cycles each → PARITY if PARITY≠0, else STOP.
  - PARITY: even parity = XOR of data bits; odd parity = its inverse; DIV cycles → STOP.
  - STOP: `o_tx`=1 for STOP_BITS×DIV cycles → IDLE.
    - `o_byte_done` pulses in the first IDLE cycle.
    - `o_finsh_flag` pulses in that same cycle if `i_fifo_empty`=1 there.
    - `o_busy` drops in that same cycle.
- Latency:
  - First edge sampling non-empty (cycle N) → `o_fifo_rden` high in N+1 → LOAD in N+2 → `o_tx` low from N+3.
  - Back-to-back frames have a 3-cycle high gap between the last stop bit and the next start bit.
- Config changes: `set_bps`/`set_clk_freq` changes mid-frame are ignored; they take effect at the next LOAD.
- `i_tx_en` deasserted mid-frame: the current frame finishes and no further pops occur.
- `i_fifo_empty` is never consulted outside IDLE; a pop on an empty FIFO is impossible by construction.
- Reset mid-frame: at the next edge `o_tx`=1, state IDLE, all pulses 0. The partially sent byte is lost; no `o_byte_done`, no `o_finsh_flag`.
- Baud counter: counts 0..DIV-1 and wraps. `bit_tick` asserts at count DIV-1. The counter clears in LOAD so each bit is exactly DIV cycles.

Decomposition:
- Shared package `uart_pkg`:
  - baud divisor table function `bps_div(set_bps, set_clk_freq)`, shared with RX
  - parity constants PAR_NONE, PAR_ODD, PAR_EVEN
  - TX state encoding
  - DIV_W=15
- One sub-module, `uart_baud_cnt`: divisor load/clear, counter, `bit_tick` output. It is reusable by RX with a half-period tap.

Test Plan:
1. 50 MHz, `set_bps`=2, FIFO holds 0x55:
   - one `o_fifo_rden` pulse
   - `o_tx` reads 0,1,0,1,0,1,0,1,0,1, each level held 5208 cycles, total 52080 cycles
   - `o_byte_done` and `o_finsh_flag` each pulse once
2. FIFO preloaded with 0x00..0x07:
   - 8 rden pulses; 8 frames decoded by the bench RX model equal 0..7 in order
   - 3-cycle gaps between frames
   - 8 `o_byte_done` pulses, exactly one `o_finsh_flag` after the last frame
3. Parity:
   - PARITY=2, byte 0x07 → parity bit 1.
   - PARITY=1, byte 0x07 → 0.
   - STOP_BITS=2 → stop high for 2×DIV cycles.
4. Config change: `set_bps` changes 2→6 during the data bits of frame 1 → frame 1 bits are 5208 cycles, frame 2 bits are 434 cycles.
5. Reset mid-frame: `i_sys_rst_n`=0 during data bit 3 → next edge `o_tx`=1, `o_busy`=0, no pulses. After release, remaining FIFO bytes transmit normally.
6. Gating and 25 MHz timing:
   - `i_tx_en`=0 with non-empty FIFO → no rden for 10000 cycles.
   - Then `set_clk_freq`=0, `set_bps`=7, enable → 109 cycles per bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-period divisor table, parity modes and TX state encoding.
package uart_pkg;

  localparam int unsigned DIV_W = 15;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_RD,
    TX_LOAD,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  // Clock cycles per bit, round(fclk/baud); set_clk_freq=1 selects 50 MHz, 0 selects 25 MHz.
  function automatic logic [DIV_W-1:0] bps_div(input logic [2:0] set_bps,
                                               input logic       set_clk_freq);
    logic [DIV_W-1:0] div;
    div = DIV_W'(217);
    if (set_clk_freq) begin
      case (set_bps)
        3'd0:    div = DIV_W'(20833);
        3'd1:    div = DIV_W'(10417);
        3'd2:    div = DIV_W'(5208);
        3'd3:    div = DIV_W'(2604);
        3'd4:    div = DIV_W'(1302);
        3'd5:    div = DIV_W'(868);
        3'd6:    div = DIV_W'(434);
        default: div = DIV_W'(217);
      endcase
    end else begin
      case (set_bps)
        3'd0:    div = DIV_W'(10417);
        3'd1:    div = DIV_W'(5208);
        3'd2:    div = DIV_W'(2604);
        3'd3:    div = DIV_W'(1302);
        3'd4:    div = DIV_W'(651);
        3'd5:    div = DIV_W'(434);
        3'd6:    div = DIV_W'(217);
        default: div = DIV_W'(109);
      endcase
    end
    return div;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: i_clr latches a new divisor and restarts the count; o_bit_tick
// is high during the last cycle of every bit period (count == div-1).
module uart_baud_cnt
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_bit_tick
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Tick is registered from the next count so it lines up with cnt_q == div_q-1.
  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (i_clr) begin
      div_d = i_div;
      cnt_d = '0;
    end else if (tick_q) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    tick_d = (cnt_d == (div_d - DIV_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q  <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign o_bit_tick = tick_q;

endmodule

// File: rtl/uart_tx_ser.sv
// UART transmit serializer: pops one byte per frame from the TX FIFO and sends it
// LSB first as start / data / optional parity / stop bits on o_tx.
module uart_tx_ser
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PARITY     = PAR_NONE,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  input  logic                  i_tx_en,
  input  logic [2:0]            set_bps,
  input  logic                  set_clk_freq,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
  output logic                  o_fifo_rden,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_byte_done,
  output logic                  o_finsh_flag
);

  localparam int unsigned     IDX_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  stop_idx_q, stop_idx_d;
  logic                  par_q, par_d;

  logic tx_q, tx_d;
  logic rden_q, rden_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic fin_q, fin_d;

  logic             bit_tick;
  logic             baud_clr;
  logic [DIV_W-1:0] div_sel;

  assign baud_clr = (state_q == TX_LOAD);
  assign div_sel  = bps_div(set_bps, set_clk_freq);

  uart_baud_cnt u_baud_cnt (
    .clk        (i_sys_clk),
    .rst_n      (i_sys_rst_n),
    .i_clr      (baud_clr),
    .i_div      (div_sel),
    .o_bit_tick (bit_tick)
  );

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      state_q <= TX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:   if (i_tx_en && !i_fifo_empty) state_d = TX_RD;
      TX_RD:     state_d = TX_LOAD;
      TX_LOAD:   state_d = TX_START;
      TX_START:  if (bit_tick) state_d = TX_DATA;
      TX_DATA: begin
        if (bit_tick && (bit_idx_q == LAST_IDX)) begin
          state_d = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
        end
      end
      TX_PARITY: if (bit_tick) state_d = TX_STOP;
      TX_STOP:   if (bit_tick && (stop_idx_q == LAST_STOP)) state_d = TX_IDLE;
      default:   state_d = TX_IDLE;
    endcase
  end

  // Shift register, bit/stop indices and parity; the FIFO word is valid during LOAD.
  always_comb begin
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    par_d      = par_q;
    case (state_q)
      TX_LOAD: begin
        shift_d    = i_fifo_rdata;
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
        par_d      = (PARITY == PAR_ODD) ? ~(^i_fifo_rdata) : (^i_fifo_rdata);
      end
      TX_DATA: begin
        if (bit_tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + IDX_W'(1);
        end
      end
      TX_STOP: begin
        if (bit_tick) stop_idx_d = stop_idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_comb begin
    tx_d   = 1'b1;
    rden_d = 1'b0;
    busy_d = (state_d != TX_IDLE);
    done_d = 1'b0;
    fin_d  = 1'b0;
    case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = shift_d[0];
      TX_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
    if ((state_q == TX_IDLE) && (state_d == TX_RD)) rden_d = 1'b1;
    if ((state_q == TX_STOP) && (state_d == TX_IDLE)) begin
      done_d = 1'b1;
      fin_d  = i_fifo_empty;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      rden_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      rden_q     <= rden_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fin_q      <= fin_d;
    end
  end

  assign o_tx         = tx_q;
  assign o_fifo_rden  = rden_q;
  assign o_busy       = busy_q;
  assign o_byte_done  = done_q;
  assign o_finsh_flag = fin_q;

endmodule
